// File: rtl/cpu_sequencer.sv
// Cycle sequencer: one-hot phase generation, skip flip-flop and
// retired-instruction counter between the IR/ALU flags and control decode.
module cpu_sequencer #(
  parameter logic [15:0] EXEC2_MASK = 16'h0000,
  parameter logic [3:0]  STP_OPC    = 4'h7,
  parameter logic [3:0]  SKIP_OPC   = 4'hB,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             mem_ready,
  input  logic [3:0]       C,
  input  logic             EQ,
  output logic [2:0]       Q,
  output logic             skipff,
  output logic             halted,
  output logic             idle,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  logic is_stp;
  logic is_skip;
  logic needs_ex2;
  logic sel_skip;
  logic sel_stp;
  logic sel_ex2;
  logic end_state;

  assign is_stp    = (C == STP_OPC);
  assign is_skip   = (C == SKIP_OPC);
  assign needs_ex2 = EXEC2_MASK[C];

  // EXEC1 exit priority flattened into exclusive selects
  assign sel_skip = skipff;
  assign sel_stp  = ~skipff & is_stp;
  assign sel_ex2  = ~skipff & ~is_stp & needs_ex2;

  assign end_state = step_mode;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) state_nx = S_EXEC1;
      end
      S_EXEC1: begin
        unique case (1'b1)
          sel_skip: state_nx = S_FETCH;
          sel_stp:  state_nx = S_HALT;
          sel_ex2:  state_nx = S_EXEC2;
          default:  state_nx = end_state ? S_IDLE
                                         : S_FETCH;
        endcase
      end
      S_EXEC2: begin
        state_nx = end_state ? S_IDLE : S_FETCH;
      end
      S_HALT: begin
        if (start) state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      Q           <= 3'b000;
      idle        <= 1'b1;
      halted      <= 1'b0;
      skipff      <= 1'b0;
      instr_count <= '0;
    end else begin
      state  <= state_nx;
      Q      <= {state_nx == S_FETCH,
                 state_nx == S_EXEC2,
                 state_nx == S_EXEC1};
      idle   <= (state_nx == S_IDLE);
      halted <= (state_nx == S_HALT);
      if (state == S_EXEC1) begin
        skipff      <= is_skip & EQ & ~skipff;
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: vector table plus hand-written
// wrap and asynchronous-reset sequences.
module tb_cpu_sequencer;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             step_mode;
  logic             mem_ready;
  logic [3:0]       C;
  logic             EQ;
  logic [2:0]       Q;
  logic             skipff;
  logic             halted;
  logic             idle;
  logic [CNT_W-1:0] instr_count;

  int n_tests;
  int n_fail;

  cpu_sequencer #(
    .EXEC2_MASK(16'h0001),
    .STP_OPC   (4'h7),
    .SKIP_OPC  (4'hB),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .step_mode  (step_mode),
    .mem_ready  (mem_ready),
    .C          (C),
    .EQ         (EQ),
    .Q          (Q),
    .skipff     (skipff),
    .halted     (halted),
    .idle       (idle),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       step;
    logic       mr;
    logic [3:0] c;
    logic       eq;
    logic [2:0] q;
    logic       skip;
    logic       halt;
    logic       idl;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic sm,
                     input logic mr, input logic [3:0] c,
                     input logic eq, input logic [2:0] q,
                     input logic sk, input logic hl,
                     input logic id, input logic [3:0] cnt);
    vec_t v;
    v.start = st; v.step = sm; v.mr = mr;
    v.c = c; v.eq = eq; v.q = q; v.skip = sk;
    v.halt = hl; v.idl = id; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name,
                       input logic [2:0] eq_q,
                       input logic e_sk, input logic e_hl,
                       input logic e_id, input logic [3:0] e_cnt);
    n_tests++;
    if (Q !== eq_q || skipff !== e_sk ||
        halted !== e_hl || idle !== e_id ||
        instr_count !== e_cnt) begin
      n_fail++;
      $display("FAIL %s: got Q=%b sk=%b hl=%b id=%b cnt=%0d want Q=%b sk=%b hl=%b id=%b cnt=%0d",
               name, Q, skipff, halted, idle, instr_count,
               eq_q, e_sk, e_hl, e_id, e_cnt);
    end
  endtask

  task automatic drive(input logic st, input logic sm,
                       input logic mr, input logic [3:0] c,
                       input logic eq);
    start = st; step_mode = sm; mem_ready = mr;
    C = c; EQ = eq;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] cnt_m;
  logic       saw_zero;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 4'h0, 0);

    // T2 run
    add(0,0,1,4'h2,0, 3'b000,0,0,1,4'd0);
    add(1,0,1,4'h2,0, 3'b100,0,0,0,4'd0);
    add(0,0,1,4'h2,0, 3'b001,0,0,0,4'd0);
    add(0,0,1,4'h2,0, 3'b100,0,0,0,4'd1);
    add(0,0,1,4'h2,0, 3'b001,0,0,0,4'd1);
    add(0,0,1,4'h2,0, 3'b100,0,0,0,4'd2);
    // T3 memory wait
    add(0,0,0,4'h2,0, 3'b100,0,0,0,4'd2);
    add(0,0,0,4'h2,0, 3'b100,0,0,0,4'd2);
    add(0,0,0,4'h2,0, 3'b100,0,0,0,4'd2);
    add(0,0,1,4'h2,0, 3'b001,0,0,0,4'd2);
    add(0,0,1,4'h2,0, 3'b100,0,0,0,4'd3);
    // T4 EXEC2
    add(0,0,1,4'h0,0, 3'b001,0,0,0,4'd3);
    add(0,0,1,4'h0,0, 3'b010,0,0,0,4'd4);
    add(0,0,1,4'h0,0, 3'b100,0,0,0,4'd4);
    // T5 skip over STP
    add(0,0,1,4'hB,1, 3'b001,0,0,0,4'd4);
    add(0,0,1,4'hB,1, 3'b100,1,0,0,4'd5);
    add(0,0,1,4'h7,0, 3'b001,1,0,0,4'd5);
    add(0,0,1,4'h7,0, 3'b100,0,0,0,4'd6);
    // T5 no skip, STP halts
    add(0,0,1,4'hB,0, 3'b001,0,0,0,4'd6);
    add(0,0,1,4'hB,0, 3'b100,0,0,0,4'd7);
    add(0,0,1,4'h7,0, 3'b001,0,0,0,4'd7);
    add(0,0,1,4'h7,0, 3'b000,0,1,0,4'd8);
    add(0,0,1,4'h7,0, 3'b000,0,1,0,4'd8);
    add(1,0,1,4'h2,0, 3'b100,0,0,0,4'd8);
    // skipped skip does not re-arm
    add(0,0,1,4'hB,1, 3'b001,0,0,0,4'd8);
    add(0,0,1,4'hB,1, 3'b100,1,0,0,4'd9);
    add(0,0,1,4'hB,1, 3'b001,1,0,0,4'd9);
    add(0,0,1,4'hB,1, 3'b100,0,0,0,4'd10);
    // T6 single-step
    add(0,1,1,4'h2,0, 3'b001,0,0,0,4'd10);
    add(0,1,1,4'h2,0, 3'b000,0,0,1,4'd11);
    add(0,1,1,4'h2,0, 3'b000,0,0,1,4'd11);
    add(1,1,1,4'h2,0, 3'b100,0,0,0,4'd11);
    add(0,1,1,4'h2,0, 3'b001,0,0,0,4'd11);
    add(0,1,1,4'h2,0, 3'b000,0,0,1,4'd12);
    add(1,1,1,4'h0,0, 3'b100,0,0,0,4'd12);
    add(0,1,1,4'h0,0, 3'b001,0,0,0,4'd12);
    add(0,1,1,4'h0,0, 3'b010,0,0,0,4'd13);
    add(0,1,1,4'h0,0, 3'b000,0,0,1,4'd13);

    #12;
    check("reset_state", 3'b000, 0, 0, 1, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].start, vecs[i].step, vecs[i].mr,
            vecs[i].c, vecs[i].eq);
      tick();
      check($sformatf("vec%0d", i), vecs[i].q,
            vecs[i].skip, vecs[i].halt, vecs[i].idl,
            vecs[i].cnt);
    end

    // Counter wrap: run 20 one-cycle instructions
    cnt_m = 4'd13;
    saw_zero = 1'b0;
    @(negedge clk);
    drive(1, 0, 1, 4'h2, 0);
    tick();
    check("wrap_launch", 3'b100, 0, 0, 0, cnt_m);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(0, 0, 1, 4'h2, 0);
      tick();
      check("wrap_ex1", 3'b001, 0, 0, 0, cnt_m);
      tick();
      cnt_m = cnt_m + 4'd1;
      if (cnt_m == 4'd0) saw_zero = 1'b1;
      check($sformatf("wrap%0d", k), 3'b100, 0, 0, 0,
            cnt_m);
    end
    n_tests++;
    if (instr_count !== 4'd1 || !saw_zero) begin
      n_fail++;
      $display("FAIL wrap_final: got cnt=%0d want 1",
               instr_count);
    end

    // Skip held through FETCH wait, then async reset clears it
    @(negedge clk);
    drive(0, 0, 1, 4'hB, 1);
    tick();
    check("arm_ex1", 3'b001, 0, 0, 0, 4'd1);
    tick();
    check("arm_fetch", 3'b100, 1, 0, 0, 4'd2);
    @(negedge clk);
    drive(0, 0, 0, 4'h2, 0);
    tick();
    check("skip_hold", 3'b100, 1, 0, 0, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_fetch", 3'b000, 0, 0, 1, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1 reset mid-EXEC2
    drive(1, 0, 1, 4'h0, 0);
    tick();
    @(negedge clk);
    drive(0, 0, 1, 4'h0, 0);
    tick();
    tick();
    check("pre_rst_ex2", 3'b010, 0, 0, 0, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_exec2", 3'b000, 0, 0, 1, 4'd0);
    @(negedge clk);
    tick();
    check("rst_hold", 3'b000, 0, 0, 1, 4'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
